// File: rtl/cpu_mem_xfer_if.sv
// Bus bundle between the Chip-8 block-transfer engine and its environment:
// decoder request, register-file port, I register update and memory port A.
interface cpu_mem_xfer_if;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  x;
   logic [11:0] i_in;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  reg_idx;
   logic [7:0]  reg_rdata;
   logic        reg_we;
   logic [7:0]  reg_wdata;
   logic        i_we;
   logic [11:0] i_out;
   logic        mem_en;
   logic        mem_write;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   // Engine side: owns port A, the register-file strobes and the I update.
   modport master (
      input  start, op, x, i_in, reg_rdata, mem_rdata,
      output busy, done, err, reg_idx, reg_we, reg_wdata,
             i_we, i_out, mem_en, mem_write, mem_addr, mem_wdata
   );

   // Environment side: decoder, register file and memory.
   modport slave (
      output start, op, x, i_in, reg_rdata, mem_rdata,
      input  busy, done, err, reg_idx, reg_we, reg_wdata,
             i_we, i_out, mem_en, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cpu_mem_xfer.sv
// Block-transfer engine for Chip-8 FX33 (BCD), FX55 (store) and FX65 (load)
// between the register file and memory port A.
module cpu_mem_xfer #(
   parameter bit          I_INC      = 1'b1,
   parameter int unsigned PROT_LIMIT = 512
) (
   input  logic           clk,
   input  logic           reset,
   cpu_mem_xfer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_BCD_RD, S_BCD_WR, S_STORE, S_LOAD, S_FIN
   } state_t;

   typedef enum logic [1:0] {
      OP_BCD = 2'd0, OP_STORE = 2'd1, OP_LOAD = 2'd2, OP_INVALID = 2'd3
   } op_t;

   state_t      state;
   op_t         op_q;
   logic [3:0]  x_q;
   logic [11:0] i_q;
   logic [4:0]  k;
   logic [3:0]  tens_q;
   logic [3:0]  ones_q;
   logic        prot_q;

   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [3:0]  reg_idx_q;
   logic        reg_we_q;
   logic        i_we_q;
   logic [11:0] i_out_q;
   logic        mem_en_q;
   logic        mem_write_q;
   logic [11:0] mem_addr_q;
   logic [7:0]  bcd_wdata_q;

   logic [4:0]  k_next;
   logic [11:0] addr_next;
   logic        wr_prot;
   logic        to_fin;

   // Step helpers: next counter/address, protected-write detect, last-step detect.
   always_comb begin
      k_next    = k + 5'd1;
      addr_next = i_q + {7'd0, k_next};
      wr_prot   = mem_en_q && mem_write_q && ({20'd0, mem_addr_q} < PROT_LIMIT);
      to_fin    = 1'b0;
      case (state)
         S_BCD_WR: to_fin = (k == 5'd2);
         S_STORE:  to_fin = (k == {1'b0, x_q});
         S_LOAD:   to_fin = (k == ({1'b0, x_q} + 5'd1));
         default:  to_fin = 1'b0;
      endcase
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.reg_idx   = reg_idx_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.i_we      = i_we_q;
   assign bus.i_out     = i_out_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   // Data paths that bypass the registers so one byte moves per cycle.
   assign bus.mem_wdata = (state == S_STORE) ? bus.reg_rdata : bcd_wdata_q;
   assign bus.reg_wdata = (state == S_LOAD) ? bus.mem_rdata : 8'd0;

   // Sequencer: outputs are registered alongside the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         op_q        <= OP_BCD;
         x_q         <= '0;
         i_q         <= '0;
         k           <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
         prot_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         reg_idx_q   <= '0;
         reg_we_q    <= 1'b0;
         i_we_q      <= 1'b0;
         i_out_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         bcd_wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         i_we_q <= 1'b0;
         if (state != S_IDLE) prot_q <= prot_q | wr_prot;
         if (to_fin) begin
            state       <= S_FIN;
            done_q      <= 1'b1;
            err_q       <= prot_q | wr_prot;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            bcd_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_idx_q   <= '0;
            if (I_INC && (op_q != OP_BCD)) begin
               i_we_q  <= 1'b1;
               i_out_q <= i_q + {8'd0, x_q} + 12'd1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     op_q   <= op_t'(bus.op);
                     x_q    <= bus.x;
                     i_q    <= bus.i_in;
                     k      <= '0;
                     err_q  <= 1'b0;
                     prot_q <= 1'b0;
                     busy_q <= 1'b1;
                     case (op_t'(bus.op))
                        OP_BCD: begin
                           state     <= S_BCD_RD;
                           reg_idx_q <= bus.x;
                        end
                        OP_STORE: begin
                           state       <= S_STORE;
                           reg_idx_q   <= '0;
                           mem_en_q    <= 1'b1;
                           mem_write_q <= 1'b1;
                           mem_addr_q  <= bus.i_in;
                        end
                        OP_LOAD: begin
                           state       <= S_LOAD;
                           reg_idx_q   <= '0;
                           mem_en_q    <= 1'b1;
                           mem_write_q <= 1'b0;
                           mem_addr_q  <= bus.i_in;
                        end
                        default: begin
                           state  <= S_FIN;
                           done_q <= 1'b1;
                           err_q  <= 1'b1;
                        end
                     endcase
                  end
               end
               S_BCD_RD: begin
                  state       <= S_BCD_WR;
                  k           <= '0;
                  reg_idx_q   <= '0;
                  bcd_wdata_q <= bus.reg_rdata / 8'd100;
                  tens_q      <= 4'((bus.reg_rdata % 8'd100) / 8'd10);
                  ones_q      <= 4'(bus.reg_rdata % 8'd10);
                  mem_en_q    <= 1'b1;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= i_q;
               end
               S_BCD_WR: begin
                  k           <= k_next;
                  mem_addr_q  <= addr_next;
                  bcd_wdata_q <= (k == 5'd0) ? {4'd0, tens_q} : {4'd0, ones_q};
               end
               S_STORE: begin
                  k          <= k_next;
                  reg_idx_q  <= k_next[3:0];
                  mem_addr_q <= addr_next;
               end
               S_LOAD: begin
                  // Read for step k_next issues while the byte from step k lands.
                  k           <= k_next;
                  mem_en_q    <= (k_next <= {1'b0, x_q});
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= (k_next <= {1'b0, x_q}) ? addr_next : 12'd0;
                  reg_we_q    <= 1'b1;
                  reg_idx_q   <= k[3:0];
               end
               S_FIN: begin
                  state   <= S_IDLE;
                  busy_q  <= 1'b0;
                  i_out_q <= '0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
